// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes a MIPS-I integer instruction into the ALU opcode,
// selects and extends the operands, and registers the results as the ID/EX
// pipeline register with stall and flush handling.
module alu_issue_stage #(
    parameter int RESET_PC_VALID = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        stall,
    input  logic        flush,
    output logic        id_ready,
    output logic        ex_valid,
    output logic [3:0]  ex_alu_ctrl,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [4:0]  ex_dest,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [31:0] ex_store_data,
    output logic        ex_illegal
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_LUI = 4'b1001;
    localparam logic [3:0] ALU_SRL = 4'b1010;
    localparam logic [3:0] ALU_SRA = 4'b1011;

    localparam logic RESET_VALID = (RESET_PC_VALID != 0);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt_field;
    logic [4:0]  rd_field;
    logic [4:0]  shamt;
    logic [31:0] imm_se;
    logic [31:0] imm_ze;

    // The rs field is not decoded here: rs data arrives already read and forwarded.
    logic unused_rs_field;
    assign unused_rs_field = ^id_instr[25:21];

    assign op       = id_instr[31:26];
    assign rt_field = id_instr[20:16];
    assign rd_field = id_instr[15:11];
    assign shamt    = id_instr[10:6];
    assign funct    = id_instr[5:0];
    assign imm_se   = {{16{id_instr[15]}}, id_instr[15:0]};
    assign imm_ze   = {16'h0000, id_instr[15:0]};

    // Decode may advance whenever the EX register is not being held.
    assign id_ready = !stall;

    logic [3:0]  dec_alu_ctrl;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [4:0]  dec_dest;
    logic        dec_reg_write;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_illegal;

    // Combinational decode of the instruction currently presented by ID.
    always_comb begin
        dec_alu_ctrl  = ALU_AND;
        dec_a         = id_rs_data;
        dec_b         = id_rt_data;
        dec_dest      = rt_field;
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_illegal   = 1'b0;

        case (op)
            6'h00: begin
                dec_dest = rd_field;
                case (funct)
                    6'h20, 6'h21: dec_alu_ctrl = ALU_ADD;
                    6'h22, 6'h23: dec_alu_ctrl = ALU_SUB;
                    6'h24:        dec_alu_ctrl = ALU_AND;
                    6'h25:        dec_alu_ctrl = ALU_OR;
                    6'h26:        dec_alu_ctrl = ALU_XOR;
                    6'h2A:        dec_alu_ctrl = ALU_SLT;
                    6'h00: begin
                        dec_alu_ctrl = ALU_SLL;
                        dec_a        = {27'b0, shamt};
                    end
                    6'h02: begin
                        dec_alu_ctrl = ALU_SRL;
                        dec_a        = {27'b0, shamt};
                    end
                    6'h03: begin
                        dec_alu_ctrl = ALU_SRA;
                        dec_a        = {27'b0, shamt};
                    end
                    6'h04:        dec_alu_ctrl = ALU_SLL;
                    6'h06:        dec_alu_ctrl = ALU_SRL;
                    6'h07:        dec_alu_ctrl = ALU_SRA;
                    default:      dec_illegal  = 1'b1;
                endcase
            end
            6'h08, 6'h09: begin
                dec_alu_ctrl = ALU_ADD;
                dec_b        = imm_se;
            end
            6'h0A: begin
                dec_alu_ctrl = ALU_SLT;
                dec_b        = imm_se;
            end
            6'h0C: begin
                dec_alu_ctrl = ALU_AND;
                dec_b        = imm_ze;
            end
            6'h0D: begin
                dec_alu_ctrl = ALU_OR;
                dec_b        = imm_ze;
            end
            6'h0E: begin
                dec_alu_ctrl = ALU_XOR;
                dec_b        = imm_ze;
            end
            6'h0F: begin
                dec_alu_ctrl = ALU_LUI;
                dec_a        = 32'h0;
                dec_b        = imm_ze;
            end
            6'h23: begin
                dec_alu_ctrl = ALU_ADD;
                dec_b        = imm_se;
                dec_mem_read = 1'b1;
            end
            6'h2B: begin
                dec_alu_ctrl  = ALU_ADD;
                dec_b         = imm_se;
                dec_mem_write = 1'b1;
                dec_reg_write = 1'b0;
            end
            6'h04, 6'h05: begin
                dec_alu_ctrl  = ALU_SUB;
                dec_reg_write = 1'b0;
            end
            default: dec_illegal = 1'b1;
        endcase

        if (dec_illegal) begin
            dec_alu_ctrl  = ALU_AND;
            dec_a         = 32'h0;
            dec_b         = 32'h0;
            dec_dest      = 5'd0;
            dec_reg_write = 1'b0;
            dec_mem_read  = 1'b0;
            dec_mem_write = 1'b0;
        end

        // Writes to $0 are discarded, which also makes 0x00000000 a no-op.
        if (dec_dest == 5'd0) begin
            dec_reg_write = 1'b0;
        end
    end

    // ID/EX register: flush beats stall, stall holds, an empty slot loads a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid      <= RESET_VALID;
            ex_alu_ctrl   <= ALU_AND;
            ex_a          <= 32'h0;
            ex_b          <= 32'h0;
            ex_dest       <= 5'd0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_store_data <= 32'h0;
            ex_illegal    <= 1'b0;
        end else if (flush || (!stall && !id_valid)) begin
            ex_valid      <= 1'b0;
            ex_alu_ctrl   <= ALU_AND;
            ex_a          <= 32'h0;
            ex_b          <= 32'h0;
            ex_dest       <= 5'd0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_store_data <= 32'h0;
            ex_illegal    <= 1'b0;
        end else if (!stall) begin
            ex_valid      <= 1'b1;
            ex_alu_ctrl   <= dec_alu_ctrl;
            ex_a          <= dec_a;
            ex_b          <= dec_b;
            ex_dest       <= dec_dest;
            ex_reg_write  <= dec_reg_write;
            ex_mem_read   <= dec_mem_read;
            ex_mem_write  <= dec_mem_write;
            ex_store_data <= id_rt_data;
            ex_illegal    <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors for the ID/EX issue stage, checked every
// cycle against an instruction-level model plus hand-computed literal values.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        idValid = 1'b0;
    logic [31:0] idInstr = 32'h0;
    logic [31:0] idRsData = 32'h0;
    logic [31:0] idRtData = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        idReady;
    logic        exValid;
    logic [3:0]  exAluCtrl;
    logic [31:0] exA;
    logic [31:0] exB;
    logic [4:0]  exDest;
    logic        exRegWrite;
    logic        exMemRead;
    logic        exMemWrite;
    logic [31:0] exStoreData;
    logic        exIllegal;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        valid;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic [31:0] storeData;
        logic        illegal;
    } exSlot;

    exSlot expSlot = '0;

    alu_issue_stage #(.RESET_PC_VALID(0)) dut (
        .clk(clk),
        .rst(rst),
        .id_valid(idValid),
        .id_instr(idInstr),
        .id_rs_data(idRsData),
        .id_rt_data(idRtData),
        .stall(stall),
        .flush(flush),
        .id_ready(idReady),
        .ex_valid(exValid),
        .ex_alu_ctrl(exAluCtrl),
        .ex_a(exA),
        .ex_b(exB),
        .ex_dest(exDest),
        .ex_reg_write(exRegWrite),
        .ex_mem_read(exMemRead),
        .ex_mem_write(exMemWrite),
        .ex_store_data(exStoreData),
        .ex_illegal(exIllegal)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // What an instruction means to the ALU, written per mnemonic.
    function automatic exSlot modelDecode(input logic [31:0] instr, input logic [31:0] rs,
                                          input logic [31:0] rt);
        exSlot s;
        logic [31:0] sext;
        logic [31:0] zext;
        sext = {{16{instr[15]}}, instr[15:0]};
        zext = {16'h0, instr[15:0]};
        s = '0;
        s.valid = 1'b1;
        s.storeData = rt;
        s.a = rs;
        if (instr[31:26] == 6'h00) begin
            s.b = rt;
            s.dest = instr[15:11];
            s.regWrite = 1'b1;
            case (instr[5:0])
                6'h20, 6'h21: s.ctrl = 4'b0010;
                6'h22, 6'h23: s.ctrl = 4'b0110;
                6'h24: s.ctrl = 4'b0000;
                6'h25: s.ctrl = 4'b0001;
                6'h26: s.ctrl = 4'b0011;
                6'h2A: s.ctrl = 4'b0111;
                6'h00: begin s.ctrl = 4'b1000; s.a = 32'(instr[10:6]); end
                6'h02: begin s.ctrl = 4'b1010; s.a = 32'(instr[10:6]); end
                6'h03: begin s.ctrl = 4'b1011; s.a = 32'(instr[10:6]); end
                6'h04: s.ctrl = 4'b1000;
                6'h06: s.ctrl = 4'b1010;
                6'h07: s.ctrl = 4'b1011;
                default: s.illegal = 1'b1;
            endcase
        end else begin
            s.dest = instr[20:16];
            s.regWrite = 1'b1;
            case (instr[31:26])
                6'h08, 6'h09: begin s.ctrl = 4'b0010; s.b = sext; end
                6'h0A: begin s.ctrl = 4'b0111; s.b = sext; end
                6'h0C: begin s.ctrl = 4'b0000; s.b = zext; end
                6'h0D: begin s.ctrl = 4'b0001; s.b = zext; end
                6'h0E: begin s.ctrl = 4'b0011; s.b = zext; end
                6'h0F: begin s.ctrl = 4'b1001; s.a = 32'h0; s.b = zext; end
                6'h23: begin s.ctrl = 4'b0010; s.b = sext; s.memRead = 1'b1; end
                6'h2B: begin s.ctrl = 4'b0010; s.b = sext; s.memWrite = 1'b1; s.regWrite = 1'b0; end
                6'h04, 6'h05: begin s.ctrl = 4'b0110; s.b = rt; s.regWrite = 1'b0; end
                default: s.illegal = 1'b1;
            endcase
        end
        if (s.illegal) begin
            s.ctrl = 4'b0000;
            s.a = 32'h0;
            s.b = 32'h0;
            s.dest = 5'd0;
            s.regWrite = 1'b0;
            s.memRead = 1'b0;
            s.memWrite = 1'b0;
        end
        if (s.dest == 5'd0) s.regWrite = 1'b0;
        return s;
    endfunction

    // Expected EX slot contents, advanced with the same edge priority the stage promises.
    always @(posedge clk or posedge rst) begin
        if (rst) expSlot = '0;
        else if (flush) expSlot = '0;
        else if (stall) expSlot = expSlot;
        else if (!idValid) expSlot = '0;
        else expSlot = modelDecode(idInstr, idRsData, idRtData);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare the whole EX slot against the model on every falling edge.
    always @(negedge clk) begin
        checkOutput("model id_ready", 32'(idReady), 32'(!stall));
        checkOutput("model valid", 32'(exValid), 32'(expSlot.valid));
        checkOutput("model ctrl", 32'(exAluCtrl), 32'(expSlot.ctrl));
        checkOutput("model a", exA, expSlot.a);
        checkOutput("model b", exB, expSlot.b);
        checkOutput("model dest", 32'(exDest), 32'(expSlot.dest));
        checkOutput("model reg_write", 32'(exRegWrite), 32'(expSlot.regWrite));
        checkOutput("model mem_read", 32'(exMemRead), 32'(expSlot.memRead));
        checkOutput("model mem_write", 32'(exMemWrite), 32'(expSlot.memWrite));
        checkOutput("model store_data", exStoreData, expSlot.storeData);
        checkOutput("model illegal", 32'(exIllegal), 32'(expSlot.illegal));
    end

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic st, input logic fl);
        @(negedge clk);
        #1;
        idValid = v;
        idInstr = instr;
        idRsData = rs;
        idRtData = rt;
        stall = st;
        flush = fl;
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk);
        checkOutput("reset valid", 32'(exValid), 32'd0);
        checkOutput("reset a", exA, 32'd0);
        checkOutput("reset id_ready", 32'(idReady), 32'd1);
        #1 rst = 1'b0;

        applyStimulus(1, 32'h00221820, 32'd5, 32'd7, 0, 0);
        afterEdge();
        checkOutput("add ctrl", 32'(exAluCtrl), 32'h2);
        checkOutput("add a", exA, 32'd5);
        checkOutput("add b", exB, 32'd7);
        checkOutput("add dest", 32'(exDest), 32'd3);
        checkOutput("add reg_write", 32'(exRegWrite), 32'd1);
        checkOutput("add valid", 32'(exValid), 32'd1);

        applyStimulus(1, 32'h00011100, 32'd0, 32'h80000001, 0, 0);
        afterEdge();
        checkOutput("sll ctrl", 32'(exAluCtrl), 32'h8);
        checkOutput("sll a", exA, 32'd4);
        checkOutput("sll b", exB, 32'h80000001);

        applyStimulus(1, 32'h3C011234, 32'h55555555, 32'd9, 0, 0);
        afterEdge();
        checkOutput("lui ctrl", 32'(exAluCtrl), 32'h9);
        checkOutput("lui a", exA, 32'd0);
        checkOutput("lui b", exB, 32'h00001234);
        checkOutput("lui dest", 32'(exDest), 32'd1);

        applyStimulus(1, 32'h2001FFFF, 32'd0, 32'd0, 0, 0);
        afterEdge();
        checkOutput("addi b", exB, 32'hFFFFFFFF);

        applyStimulus(1, 32'h3001FFFF, 32'd0, 32'd0, 0, 0);
        afterEdge();
        checkOutput("andi b", exB, 32'h0000FFFF);

        applyStimulus(1, 32'hAC220004, 32'd100, 32'hCAFEF00D, 0, 0);
        afterEdge();
        checkOutput("sw mem_write", 32'(exMemWrite), 32'd1);
        checkOutput("sw reg_write", 32'(exRegWrite), 32'd0);
        checkOutput("sw store_data", exStoreData, 32'hCAFEF00D);

        applyStimulus(1, 32'h8C22FFFC, 32'd100, 32'd1, 0, 0);
        afterEdge();
        checkOutput("lw mem_read", 32'(exMemRead), 32'd1);
        checkOutput("lw b", exB, 32'hFFFFFFFC);

        applyStimulus(1, 32'h10220003, 32'd8, 32'd8, 0, 0);
        afterEdge();
        checkOutput("beq ctrl", 32'(exAluCtrl), 32'h6);
        checkOutput("beq reg_write", 32'(exRegWrite), 32'd0);

        applyStimulus(1, 32'h00221807, 32'd3, 32'hFFFFFFF8, 0, 0);
        afterEdge();
        checkOutput("srav ctrl", 32'(exAluCtrl), 32'hB);
        checkOutput("srav a", exA, 32'd3);

        applyStimulus(1, 32'h0022183F, 32'd1, 32'd2, 0, 0);
        afterEdge();
        checkOutput("illegal flag", 32'(exIllegal), 32'd1);
        checkOutput("illegal valid", 32'(exValid), 32'd1);
        checkOutput("illegal ctrl", 32'(exAluCtrl), 32'h0);
        checkOutput("illegal reg_write", 32'(exRegWrite), 32'd0);
        checkOutput("illegal a", exA, 32'd0);

        applyStimulus(1, 32'h00000000, 32'd0, 32'd0, 0, 0);
        afterEdge();
        checkOutput("nop ctrl", 32'(exAluCtrl), 32'h8);
        checkOutput("nop reg_write", 32'(exRegWrite), 32'd0);

        applyStimulus(1, 32'h0022182A, 32'd1, 32'd2, 0, 0);
        applyStimulus(1, 32'h08000000, 32'd1, 32'd2, 0, 0);
        applyStimulus(0, 32'h00221820, 32'd1, 32'd2, 0, 0);
        afterEdge();
        checkOutput("bubble valid", 32'(exValid), 32'd0);

        applyStimulus(1, 32'h00221820, 32'd5, 32'd7, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h3C01ABCD, 32'(i + 100), 32'(i + 200), 1, 0);
            afterEdge();
            checkOutput("stall a", exA, 32'd5);
            checkOutput("stall ctrl", 32'(exAluCtrl), 32'h2);
            checkOutput("stall id_ready", 32'(idReady), 32'd0);
        end
        applyStimulus(1, 32'h3C01ABCD, 32'd1, 32'd1, 1, 1);
        afterEdge();
        checkOutput("flush valid", 32'(exValid), 32'd0);
        checkOutput("flush a", exA, 32'd0);
        checkOutput("flush b", exB, 32'd0);
        checkOutput("flush store_data", exStoreData, 32'd0);

        applyStimulus(1, 32'h00221820, 32'd5, 32'd7, 0, 0);
        applyStimulus(1, 32'h00221820, 32'd6, 32'd7, 1, 0);
        applyStimulus(1, 32'h00221822, 32'd9, 32'd4, 0, 0);
        afterEdge();
        checkOutput("stall-fall ctrl", 32'(exAluCtrl), 32'h6);
        checkOutput("stall-fall a", exA, 32'd9);

        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset valid", 32'(exValid), 32'd0);
        checkOutput("async reset a", exA, 32'd0);
        checkOutput("async reset ctrl", 32'(exAluCtrl), 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        applyStimulus(1, 32'h34220F0F, 32'd16, 32'd0, 0, 0);
        afterEdge();
        checkOutput("post reset ori b", exB, 32'h00000F0F);
        checkOutput("post reset ori ctrl", 32'(exAluCtrl), 32'h1);
        checkOutput("post reset valid", 32'(exValid), 32'd1);

        @(negedge clk);
        #1;
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute stage register that drives the ALU's `alu_ctrl`, `a` and `b` inputs.
- Decodes a MIPS-I integer instruction into the team's 4-bit ALU opcode.
- Selects and extends the operands; for fixed shifts, puts `shamt` on `a`, because the ALU shifts `b` by `a[4:0]`.
- Registers the results as the ID/EX pipeline register, with stall and flush handling.
- Sits between register-file read and the ALU.

## Interface
Parameters:
- `RESET_PC_VALID`, default 0: value of `ex_valid` after reset. Must be 0 in the CPU; nonzero only for bench use.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  `id_instr` and operand data are valid this cycle.
- `id_instr`  in  32  instruction word.
- `id_rs_data`  in  32  `rs` register value, already forwarded.
- `id_rt_data`  in  32  `rt` register value, already forwarded.
- `stall`  in  1  hold the EX register contents.
- `flush`  in  1  load a bubble.
- `id_ready`  out  1  equals `!stall`; decode may advance.
- `ex_valid`  out  1  EX slot holds a real instruction.
- `ex_alu_ctrl`  out  4  ALU opcode.
- `ex_a`  out  32  ALU operand a.
- `ex_b`  out  32  ALU operand b.
- `ex_dest`  out  5  destination register.
- `ex_reg_write`  out  1  write-back enable.
- `ex_mem_read`  out  1  load.
- `ex_mem_write`  out  1  store.
- `ex_store_data`  out  32  `rt` data for stores.
- `ex_illegal`  out  1  unsupported opcode or funct.

## Operation
ALU opcodes: AND=0000, OR=0001, ADD=0010, XOR=0011, SUB=0110, SLT=0111, SLL=1000, LUI=1001, SRL=1010, SRA=1011.

Immediate extension: SE = sign-extend `imm[15:0]`; ZE = zero-extend `imm[15:0]`.

R-type (`op=0`): `a=rs`, `b=rt`, `dest=rd`, `reg_write=1`, unless noted. By funct:
- `0x20`/`0x21` → ADD; `0x22`/`0x23` → SUB.
- `0x24` → AND; `0x25` → OR; `0x26` → XOR; `0x2A` → SLT.
- `0x00`/`0x02`/`0x03` → SLL/SRL/SRA with `a={27'b0,shamt}`.
- `0x04`/`0x06`/`0x07` → SLL/SRL/SRA with `a=rs`.
- Any other funct → illegal.

I-type: `a=rs`, `dest=rt`.
- `addi`/`addiu` (`0x08`/`0x09`): ADD, b=SE.
- `slti` (`0x0A`): SLT, b=SE.
- `andi`/`ori`/`xori` (`0x0C`/`0x0D`/`0x0E`): AND/OR/XOR, b=ZE.
- `lui` (`0x0F`): LUI, `a=0`, b=ZE.
- `lw` (`0x23`): ADD, b=SE, `mem_read=1`.
- `sw` (`0x2B`): ADD, b=SE, `mem_write=1`, `reg_write=0`.
- `beq`/`bne` (`0x04`/`0x05`): SUB, `b=rt`, `reg_write=0`; the branch compare uses the ALU `zero` output.

Write-back rules:
- `ex_reg_write` is forced to 0 when `dest==0`; `0x00000000` therefore acts as a no-op.
- `ex_store_data = id_rt_data` for every instruction.

Illegal instruction:
- `ex_illegal=1`, `ex_valid=1`, `alu_ctrl=AND`, `a=b=0`.
- `reg_write`, `mem_read` and `mem_write` all 0.

Register update priority, per rising edge:
1. `flush`: load a bubble, even if `stall` is high.
2. `stall`: hold every output unchanged.
3. `id_valid=0`: load a bubble.
4. Otherwise: load the decoded values.

A bubble is `ex_valid=0` with every other output 0; the ALU then sees AND with 0,0.

## Timing
- Latency: decode outputs appear 1 cycle after the edge that samples `id_*`. Throughput 1 instruction/cycle.
- `id_ready` is combinational from `stall` only; it has no path from `id_instr`.
- Reset: while `rst=1`, every output is 0 except `ex_valid=RESET_PC_VALID` and `id_ready=!stall`. Reset is asynchronous, so it clears the register immediately, mid-instruction included. On the first edge after deassertion, normal priority applies.
- Stall held for N cycles: outputs remain constant for N cycles. The instruction on `id_*` in the edge where `stall` falls is loaded at that edge.
- Simultaneous `flush` and `stall`: bubble, with no hold.
- Operand data is sampled at the loading edge only; a change in `id_rs_data` during a stall has no effect.

## Test plan
- `add $3,$1,$2` (`0x00221820`), `rs=5`, `rt=7`, valid → next cycle: `ctrl=0010`, `a=5`, `b=7`, `dest=3`, `reg_write=1`, `ex_valid=1`.
- `sll $2,$1,4` (`0x00011100`), `rt=0x80000001` → `ctrl=1000`, `a=4`, `b=0x80000001`. Then `lui $1,0x1234` (`0x3C011234`) → `ctrl=1001`, `a=0`, `b=0x00001234`, `dest=1`.
- Extension: `addi $1,$0,-1` (`0x2001FFFF`) → `b=0xFFFFFFFF`. `andi` (`0x3001FFFF`) → `b=0x0000FFFF`.
- Stall/flush ordering:
  - Load `add`, then stall 3 cycles while `id_instr` changes: outputs frozen.
  - Then flush with stall still high: next cycle `ex_valid=0`, all outputs 0.
- Illegal and special cases:
  - funct `0x3F` → `ex_illegal=1`, `ctrl=0000`, no writes.
  - `0x00000000` → `ctrl=1000`, `reg_write=0`.
  - `sw` → `mem_write=1`, `reg_write=0`.
- Assert `rst` asynchronously between edges with `ex_valid=1` → outputs 0 before the next edge; operation resumes after deassertion.
